// File: rtl/nibble_latch_seq_if.sv
// Word-in / latch-bus-out bundle for nibble_latch_seq.
// The master offers words; the slave sequences them onto the latch bus.
interface nibble_latch_seq_if;
    logic        WORD_VALID;
    logic [15:0] WORD;
    logic [3:0]  WORD_MASK;
    logic        WORD_READY;
    logic [3:0]  D;
    logic [3:0]  NG;
    logic        BUSY;
    logic        DONE;

    modport master (
        output WORD_VALID, WORD, WORD_MASK,
        input  WORD_READY, D, NG, BUSY, DONE
    );

    modport slave (
        input  WORD_VALID, WORD, WORD_MASK,
        output WORD_READY, D, NG, BUSY, DONE
    );
endinterface

// File: rtl/nibble_latch_seq.sv
// Sequences a 16-bit word into four external 4-bit transparent latches.
// Each masked nibble gets SETUP (data valid, gates closed), STROBE_LEN
// cycles of its active-low gate, then HOLD (gates closed, data still
// stable), so D never moves while a gate is open.
module nibble_latch_seq #(
    parameter int unsigned STROBE_LEN = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    nibble_latch_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(STROBE_LEN - 1);

    state_t      state_q;
    logic [15:0] word_q;
    logic [3:0]  mask_q;
    logic [1:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [3:0]  d_q;
    logic [3:0]  ng_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    // Nibble views of the incoming word and of the captured word.
    logic [3:0] in_nib  [4];
    logic [3:0] cap_nib [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign in_nib[gi]  = bus.WORD[4*gi +: 4];
            assign cap_nib[gi] = word_q[4*gi +: 4];
        end
    endgenerate

    // Lowest set bit of the offered mask: first nibble to write on accept.
    logic       first_found;
    logic [1:0] first_idx;

    always_comb begin
        first_found = 1'b0;
        first_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.WORD_MASK[k]) begin
                first_found = 1'b1;
                first_idx   = 2'(k);
            end
        end
    end

    // Lowest set bit of the captured mask strictly above the current index.
    logic       next_found;
    logic [1:0] next_idx;

    always_comb begin
        next_found = 1'b0;
        next_idx   = idx_q;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(idx_q))) begin
                next_found = 1'b1;
                next_idx   = 2'(k);
            end
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            word_q  <= 16'h0000;
            mask_q  <= 4'h0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            d_q     <= 4'h0;
            ng_q    <= 4'hF;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.WORD_VALID) begin
                        word_q <= bus.WORD;
                        mask_q <= bus.WORD_MASK;
                        if (first_found) begin
                            idx_q   <= first_idx;
                            d_q     <= in_nib[first_idx];
                            state_q <= SETUP;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            // Empty mask: nothing to strobe, complete at once.
                            done_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    ng_q    <= ~(4'b0001 << idx_q);
                    cnt_q   <= 4'd0;
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == LAST_CNT) begin
                        ng_q    <= 4'hF;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (next_found) begin
                        idx_q   <= next_idx;
                        d_q     <= cap_nib[next_idx];
                        state_q <= SETUP;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ng_q    <= 4'hF;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.WORD_READY = ready_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.D          = d_q;
    assign bus.NG         = ng_q;

endmodule

// File: tb/tb_nibble_latch_seq.sv
// Bench for nibble_latch_seq: two instances (STROBE_LEN 1 and 3) share the
// same stimulus. On every accepted word a reference model pushes the whole
// expected per-cycle output trace into that instance's queue; each cycle one
// entry is popped and compared with the instance outputs.
module tb_nibble_latch_seq;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] ng;
        logic       rdy;
        logic       bsy;
        logic       dn;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        word_valid;
    logic [15:0] word;
    logic [3:0]  mask;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    exp_t       q1[$];
    exp_t       q3[$];
    exp_t       scratch[$];
    logic [3:0] last1;
    logic [3:0] last3;

    nibble_latch_seq_if bus1();
    nibble_latch_seq_if bus3();

    assign bus1.WORD_VALID = word_valid;
    assign bus1.WORD       = word;
    assign bus1.WORD_MASK  = mask;
    assign bus3.WORD_VALID = word_valid;
    assign bus3.WORD       = word;
    assign bus3.WORD_MASK  = mask;

    nibble_latch_seq #(.STROBE_LEN(1)) dut1 (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus1.slave)
    );

    nibble_latch_seq #(.STROBE_LEN(3)) dut3 (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    // Expected trace of one accepted word, from the cycle after accept to the DONE cycle.
    task automatic build(input logic [15:0] w, input logic [3:0] m, input int slen,
                         input logic [3:0] lastd);
        logic [3:0] nib;
        logic [3:0] gate;
        logic [3:0] last;
        scratch.delete();
        last = lastd;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                nib     = w[4*k +: 4];
                gate    = 4'hF;
                gate[k] = 1'b0;
                scratch.push_back('{d: nib, ng: 4'hF, rdy: 1'b0, bsy: 1'b1, dn: 1'b0});
                for (int s = 0; s < slen; s++)
                    scratch.push_back('{d: nib, ng: gate, rdy: 1'b0, bsy: 1'b1, dn: 1'b0});
                scratch.push_back('{d: nib, ng: 4'hF, rdy: 1'b0, bsy: 1'b1, dn: 1'b0});
                last = nib;
            end
        end
        scratch.push_back('{d: last, ng: 4'hF, rdy: 1'b1, bsy: 1'b0, dn: 1'b1});
    endtask

    task automatic compare(input string name, input exp_t e, input logic [3:0] d,
                           input logic [3:0] ng, input logic rdy, input logic bsy,
                           input logic dn);
        check({name, ".D"},          {12'h0, d},   {12'h0, e.d});
        check({name, ".NG"},         {12'h0, ng},  {12'h0, e.ng});
        check({name, ".WORD_READY"}, {15'h0, rdy}, {15'h0, e.rdy});
        check({name, ".BUSY"},       {15'h0, bsy}, {15'h0, e.bsy});
        check({name, ".DONE"},       {15'h0, dn},  {15'h0, e.dn});
    endtask

    // One clock: model reacts to the edge, then outputs are compared 1 time unit later.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cycle++;
        if (reset) begin
            q1.delete();
            q3.delete();
            last1 = 4'h0;
            last3 = 4'h0;
        end else if (word_valid) begin
            if (q1.size() == 0) begin
                build(word, mask, 1, last1);
                foreach (scratch[i]) q1.push_back(scratch[i]);
            end
            if (q3.size() == 0) begin
                build(word, mask, 3, last3);
                foreach (scratch[i]) q3.push_back(scratch[i]);
            end
        end
        #1;
        if (q1.size() > 0) e = q1.pop_front();
        else e = '{d: last1, ng: 4'hF, rdy: 1'b1, bsy: 1'b0, dn: 1'b0};
        last1 = e.d;
        compare("len1", e, bus1.D, bus1.NG, bus1.WORD_READY, bus1.BUSY, bus1.DONE);
        if (q3.size() > 0) e = q3.pop_front();
        else e = '{d: last3, ng: 4'hF, rdy: 1'b1, bsy: 1'b0, dn: 1'b0};
        last3 = e.d;
        compare("len3", e, bus3.D, bus3.NG, bus3.WORD_READY, bus3.BUSY, bus3.DONE);
        $display("cycle %0d rst=%0b v=%0b w=%h m=%h | len1 D=%h NG=%h R=%0b Dn=%0b | len3 D=%h NG=%h R=%0b Dn=%0b",
                 cycle, reset, word_valid, word, mask, bus1.D, bus1.NG, bus1.WORD_READY,
                 bus1.DONE, bus3.D, bus3.NG, bus3.WORD_READY, bus3.DONE);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [15:0] w, input logic [3:0] m);
        word       = w;
        mask       = m;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        // Scramble inputs after accept; captured word must be unaffected.
        word = ~w;
        mask = ~m;
    endtask

    initial begin
        reset      = 1'b1;
        word_valid = 1'b0;
        word       = 16'h0000;
        mask       = 4'h0;
        last1      = 4'h0;
        last3      = 4'h0;
        run(2);
        reset = 1'b0;
        run(2);

        // Full word, all four nibbles.
        offer(16'hA5C3, 4'hF);
        run(24);

        // Sparse mask: nibbles 0 and 2 only.
        offer(16'h1234, 4'b0101);
        run(14);

        // Empty mask completes immediately.
        offer(16'hBEEF, 4'h0);
        run(3);

        // Valid held high: back-to-back acceptance in the DONE cycle.
        word       = 16'h1111;
        mask       = 4'hF;
        word_valid = 1'b1;
        step();
        word = 16'h2222;
        run(40);
        word_valid = 1'b0;
        run(24);

        // Reset mid-word aborts at that edge.
        offer(16'hFFFF, 4'hF);
        run(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(3);

        // Reset overrides a simultaneous valid.
        reset      = 1'b1;
        word_valid = 1'b1;
        word       = 16'h5A5A;
        mask       = 4'hF;
        step();
        reset      = 1'b0;
        word_valid = 1'b0;
        run(3);

        // Single nibble, exercises the multi-cycle strobe on the len3 instance.
        offer(16'h000F, 4'b0001);
        run(8);

        // Top nibble only.
        offer(16'h9000, 4'b1000);
        run(8);

        // Random words and masks.
        for (int t = 0; t < 8; t++) begin
            offer(16'($urandom), 4'($urandom_range(0, 15)));
            run(int'($urandom_range(1, 24)));
        end
        run(24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
